// File: rtl/rans_encoder_p.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : rans_encoder_p
// Brief    : rANS encoder core with serial restoring divider, word-wise
//            renormalisation and least-significant-first state flush.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
module rans_encoder_p #(
  parameter int STATE_W    = 16,
  parameter int OUT_W      = 8,
  parameter int SCALE_BITS = 4,
  parameter int CNT_W      = SCALE_BITS + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ena,
  input  logic [CNT_W-1:0]      s_freq,
  input  logic [SCALE_BITS-1:0] s_cum,
  input  logic                  flush,
  input  logic                  in_vld,
  output logic                  in_rdy,
  output logic [OUT_W-1:0]      out,
  output logic                  out_vld,
  input  logic                  out_rdy,
  output logic                  out_last,
  output logic                  err
);

  localparam int c_nw  = STATE_W / OUT_W;
  localparam int c_lw  = $clog2(c_nw + 1);
  localparam int c_dcw = $clog2(STATE_W);
  localparam logic [STATE_W-1:0] c_l     = STATE_W'(1) << (STATE_W - OUT_W);
  localparam logic [CNT_W:0]     c_total = (CNT_W + 1)'(1) << SCALE_BITS;

  localparam logic [2:0] c_st_idle   = 3'd0;
  localparam logic [2:0] c_st_check  = 3'd1;
  localparam logic [2:0] c_st_emit   = 3'd2;
  localparam logic [2:0] c_st_div    = 3'd3;
  localparam logic [2:0] c_st_update = 3'd4;
  localparam logic [2:0] c_st_flush  = 3'd5;

  logic [2:0]            r_state;
  logic [2:0]            w_state_nxt;
  logic [STATE_W-1:0]    r_x;
  logic [CNT_W-1:0]      r_freq;
  logic [SCALE_BITS-1:0] r_cum;
  logic [STATE_W-1:0]    r_quo;
  logic [CNT_W-1:0]      r_rem;
  logic [c_dcw-1:0]      r_dcnt;
  logic [c_lw-1:0]       r_left;
  logic [OUT_W-1:0]      r_out;
  logic                  r_out_vld;
  logic                  r_out_last;
  logic                  r_err;

  logic [CNT_W:0]        w_sum;
  logic                  w_illegal;
  logic                  w_need_emit;
  logic [CNT_W:0]        w_rem_sh;
  logic                  w_ge;
  logic [CNT_W-1:0]      w_diff;
  logic [STATE_W-1:0]    w_x_shr;
  logic [STATE_W-1:0]    w_x_upd;
  logic                  w_div_done;

  assign w_sum       = (CNT_W + 1)'(s_cum) + (CNT_W + 1)'(s_freq);
  assign w_illegal   = (s_freq == '0) || (w_sum > c_total);
  // x_max(f) = f << (STATE_W-SCALE_BITS) needs STATE_W+1 bits to avoid truncation
  assign w_need_emit = {1'b0, r_x} >= {r_freq, {(STATE_W - SCALE_BITS){1'b0}}};
  assign w_rem_sh    = {r_rem, r_quo[STATE_W-1]};
  assign w_ge        = w_rem_sh >= {1'b0, r_freq};
  assign w_diff      = w_rem_sh[CNT_W-1:0] - r_freq;
  assign w_x_shr     = r_x >> OUT_W;
  assign w_x_upd     = (r_quo << SCALE_BITS) + STATE_W'(r_rem) + STATE_W'(r_cum);
  assign w_div_done  = (r_dcnt == c_dcw'(STATE_W - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= c_st_idle;
    end else if (ena) begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_st_idle: begin
        if (in_vld) begin
          if (flush)           w_state_nxt = c_st_flush;
          else if (!w_illegal) w_state_nxt = c_st_check;
        end
      end
      c_st_check:  w_state_nxt = w_need_emit ? c_st_emit : c_st_div;
      c_st_emit:   if (out_rdy) w_state_nxt = c_st_check;
      c_st_div:    if (w_div_done) w_state_nxt = c_st_update;
      c_st_update: w_state_nxt = c_st_idle;
      c_st_flush:  if (out_rdy && r_out_last) w_state_nxt = c_st_idle;
      default:     w_state_nxt = c_st_idle;
    endcase
  end

  always_comb begin
    in_rdy = (r_state == c_st_idle);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_x        <= c_l;
      r_freq     <= '0;
      r_cum      <= '0;
      r_quo      <= '0;
      r_rem      <= '0;
      r_dcnt     <= '0;
      r_left     <= '0;
      r_out      <= '0;
      r_out_vld  <= 1'b0;
      r_out_last <= 1'b0;
      r_err      <= 1'b0;
    end else if (ena) begin
      r_err <= 1'b0;
      case (r_state)
        c_st_idle: begin
          if (in_vld) begin
            if (flush) begin
              r_out      <= r_x[OUT_W-1:0];
              r_out_vld  <= 1'b1;
              r_out_last <= (c_nw == 1);
              r_left     <= c_lw'(c_nw - 1);
            end else if (w_illegal) begin
              r_err <= 1'b1;
            end else begin
              r_freq <= s_freq;
              r_cum  <= s_cum;
            end
          end
        end
        c_st_check: begin
          if (w_need_emit) begin
            r_out     <= r_x[OUT_W-1:0];
            r_out_vld <= 1'b1;
          end else begin
            r_quo  <= r_x;
            r_rem  <= '0;
            r_dcnt <= '0;
          end
        end
        c_st_emit: begin
          if (out_rdy) begin
            r_x       <= w_x_shr;
            r_out_vld <= 1'b0;
          end
        end
        c_st_div: begin
          // one restoring step per cycle; quotient bits shift in behind the dividend
          r_quo  <= {r_quo[STATE_W-2:0], w_ge};
          r_rem  <= w_ge ? w_diff : w_rem_sh[CNT_W-1:0];
          r_dcnt <= r_dcnt + 1'b1;
        end
        c_st_update: begin
          r_x <= w_x_upd;
        end
        c_st_flush: begin
          if (out_rdy) begin
            if (r_out_last) begin
              r_x        <= c_l;
              r_out_vld  <= 1'b0;
              r_out_last <= 1'b0;
            end else begin
              r_x        <= w_x_shr;
              r_out      <= w_x_shr[OUT_W-1:0];
              r_out_last <= (r_left == c_lw'(1));
              r_left     <= r_left - 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign out      = r_out;
  assign out_vld  = r_out_vld;
  assign out_last = r_out_last;
  assign err      = r_err;

endmodule
`default_nettype wire

// File: tb/tb_rans_encoder_p.sv
`default_nettype none
// Testbench for rans_encoder_p: directed symbol/flush sequences with a
// queue-based scoreboard checked by an independent output monitor.
module tb_rans_encoder_p;

  localparam int STATE_W    = 16;
  localparam int OUT_W      = 8;
  localparam int SCALE_BITS = 4;
  localparam int CNT_W      = SCALE_BITS + 1;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  ena;
  logic [CNT_W-1:0]      s_freq;
  logic [SCALE_BITS-1:0] s_cum;
  logic                  flush;
  logic                  in_vld;
  logic                  in_rdy;
  logic [OUT_W-1:0]      out;
  logic                  out_vld;
  logic                  out_rdy;
  logic                  out_last;
  logic                  err;

  int n_chk  = 0;
  int n_pass = 0;
  logic [OUT_W:0] exp_q[$];

  always #5 clk = ~clk;

  rans_encoder_p #(
    .STATE_W(STATE_W), .OUT_W(OUT_W), .SCALE_BITS(SCALE_BITS), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .ena(ena), .s_freq(s_freq), .s_cum(s_cum),
    .flush(flush), .in_vld(in_vld), .in_rdy(in_rdy), .out(out),
    .out_vld(out_vld), .out_rdy(out_rdy), .out_last(out_last), .err(err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Monitor: pops the scoreboard on every output transfer and checks stall stability.
  logic           prev_stall = 1'b0;
  logic [OUT_W:0] prev_word  = '0;
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_vld", {31'd0, out_vld}, 32'd1);
        check("stall_word", {23'd0, out_last, out}, {23'd0, prev_word});
      end
      if (out_vld && out_rdy && ena) begin
        if (exp_q.size() == 0) begin
          check("unexpected_word", {23'd0, out_last, out}, 32'hDEAD_BEEF);
        end else begin
          check("out_word", {23'd0, out_last, out}, {23'd0, exp_q.pop_front()});
        end
      end
      prev_stall = out_vld && !(out_rdy && ena);
      prev_word  = {out_last, out};
    end
  end

  // Issue one command; lat = cycles from the accepting edge until in_rdy is high again.
  task automatic send(input int f, input int c, input bit fl, input bit tog, output int lat);
    int n;
    n = 0;
    while (!in_rdy && n < 200) begin @(posedge clk); #1; n++; end
    s_freq = CNT_W'(f); s_cum = SCALE_BITS'(c); flush = fl; in_vld = 1'b1;
    @(posedge clk); #1;
    in_vld = 1'b0; flush = 1'b0;
    lat = 0;
    while (!in_rdy && lat < 200) begin
      if (tog) out_rdy = ~out_rdy;
      @(posedge clk); #1;
      lat++;
    end
    out_rdy = 1'b1;
    check("in_rdy_return", {31'd0, in_rdy}, 32'd1);
  endtask

  task automatic send_illegal(input int f, input int c, input int x_exp);
    int lat;
    send(f, c, 1'b0, 1'b0, lat);
    check("illegal_err_pulse", {31'd0, err}, 32'd1);
    check("illegal_lat", lat, 0);
    @(posedge clk); #1;
    check("illegal_err_clear", {31'd0, err}, 32'd0);
    check("illegal_in_rdy", {31'd0, in_rdy}, 32'd1);
    check("illegal_x", {16'd0, dut.r_x}, x_exp);
  endtask

  initial begin
    int lat;
    int n;
    rst = 1'b1; ena = 1'b1; flush = 1'b0; in_vld = 1'b0; out_rdy = 1'b1;
    s_freq = '0; s_cum = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_rdy", {31'd0, in_rdy}, 32'd1);
    check("rst_out", {24'd0, out}, 32'd0);
    check("rst_out_vld", {31'd0, out_vld}, 32'd0);
    check("rst_out_last", {31'd0, out_last}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_x", {16'd0, dut.r_x}, 32'd256);
    rst = 1'b0;
    @(posedge clk); #1;

    // f=4,c=0 : x 256 -> 1024, no renormalisation
    send(4, 0, 1'b0, 1'b0, lat);
    check("lat_f4", lat, 18);
    check("x_f4", {16'd0, dut.r_x}, 32'd1024);
    // f=1,c=15 : 1024 -> 16399
    send(1, 15, 1'b0, 1'b0, lat);
    check("lat_f1", lat, 18);
    check("x_f1a", {16'd0, dut.r_x}, 32'd16399);
    // f=1,c=15 : emits 0x0F, then 64 -> 1039
    exp_q.push_back({1'b0, 8'h0F});
    send(1, 15, 1'b0, 1'b0, lat);
    check("x_f1b", {16'd0, dut.r_x}, 32'd1039);
    // flush with out_rdy toggling
    exp_q.push_back({1'b0, 8'h0F});
    exp_q.push_back({1'b1, 8'h04});
    send(0, 0, 1'b1, 1'b1, lat);
    check("x_after_flush", {16'd0, dut.r_x}, 32'd256);
    check("queue_drained_flush", exp_q.size(), 0);

    send_illegal(0, 0, 256);
    send_illegal(8, 12, 256);

    // reset pulse mid-DIV abandons the symbol
    s_freq = 5'd4; s_cum = 4'd0; in_vld = 1'b1;
    @(posedge clk); #1;
    in_vld = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("middiv_rst_in_rdy", {31'd0, in_rdy}, 32'd1);
    check("middiv_rst_x", {16'd0, dut.r_x}, 32'd256);
    check("middiv_rst_out_vld", {31'd0, out_vld}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("post_rst_x", {16'd0, dut.r_x}, 32'd256);
    check("post_rst_out_vld", {31'd0, out_vld}, 32'd0);

    // rebuild x=16399, then stall the emitted word with out_rdy low and ena low
    send(4, 0, 1'b0, 1'b0, lat);
    send(1, 15, 1'b0, 1'b0, lat);
    check("x_rebuild", {16'd0, dut.r_x}, 32'd16399);
    out_rdy = 1'b0;
    exp_q.push_back({1'b0, 8'h0F});
    s_freq = 5'd1; s_cum = 4'd15; in_vld = 1'b1;
    @(posedge clk); #1;
    in_vld = 1'b0;
    n = 0;
    while (!out_vld && n < 50) begin @(posedge clk); #1; n++; end
    check("emit_seen", {31'd0, out_vld}, 32'd1);
    ena = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("ena_low_out", {24'd0, out}, 32'h0F);
      check("ena_low_vld", {31'd0, out_vld}, 32'd1);
    end
    ena = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    out_rdy = 1'b1;
    n = 0;
    while (!in_rdy && n < 100) begin @(posedge clk); #1; n++; end
    check("stall_in_rdy", {31'd0, in_rdy}, 32'd1);
    check("x_after_stall", {16'd0, dut.r_x}, 32'd1039);

    // straight flush of 1039
    exp_q.push_back({1'b0, 8'h0F});
    exp_q.push_back({1'b1, 8'h04});
    send(0, 0, 1'b1, 1'b0, lat);
    check("x_final", {16'd0, dut.r_x}, 32'd256);
    repeat (3) @(posedge clk);
    #1;
    check("queue_drained_end", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
